// File: rtl/vga_pixel_pipeline.sv
// vga_pixel_pipeline: frame RAM read addressing, sync delay matching, grayscale RGB output and vsync-aligned buffer swap
module vga_pixel_pipeline #(
    parameter int PIXEL_ADDR_W = 17,
    parameter int DATA_W       = 8,
    parameter int COLOR_W      = 4,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    hsync_i,
    input  logic                    vsync_i,
    input  logic                    video_en_i,
    input  logic [PIXEL_ADDR_W-1:0] pixel_i,
    output logic [PIXEL_ADDR_W:0]   rd_addr_o,
    input  logic [DATA_W-1:0]       rd_data_i,
    input  logic                    swap_req_i,
    output logic                    swap_ack_o,
    output logic                    front_buf_o,
    output logic                    frame_start_o,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic [COLOR_W-1:0]      red_o,
    output logic [COLOR_W-1:0]      green_o,
    output logic [COLOR_W-1:0]      blue_o
);
    localparam int L = RAM_LATENCY + 2;
    typedef enum logic [1:0] {IDLE, PENDING, WAIT_DROP} state_t;
    state_t r_state, w_next;
    logic r_vs_q, w_vs_rise, w_swap, w_unused;
    logic [L-1:0] r_hs, r_vs;
    logic [L-2:0] r_ve;
    logic [COLOR_W-1:0] w_gray;
    assign w_vs_rise = vsync_i & ~r_vs_q;
    assign w_gray    = rd_data_i[DATA_W-1 -: COLOR_W];
    assign w_unused  = ^rd_data_i;
    assign hsync_o   = r_hs[L-1];
    assign vsync_o   = r_vs[L-1];
    always_comb begin
        w_swap = (r_state == PENDING) && swap_req_i && w_vs_rise;
        w_next = !swap_req_i ? IDLE : (r_state == IDLE) ? PENDING : w_swap ? WAIT_DROP : r_state;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= IDLE;
            r_vs_q        <= 1'b0;
            r_hs          <= '0;
            r_vs          <= '0;
            r_ve          <= '0;
            rd_addr_o     <= '0;
            swap_ack_o    <= 1'b0;
            front_buf_o   <= 1'b0;
            frame_start_o <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
        end else begin
            r_state       <= w_next;
            r_vs_q        <= vsync_i;
            r_hs          <= {r_hs[L-2:0], hsync_i};
            r_vs          <= {r_vs[L-2:0], vsync_i};
            r_ve          <= {r_ve[L-3:0], video_en_i};
            rd_addr_o     <= {front_buf_o, pixel_i};
            swap_ack_o    <= w_swap;
            front_buf_o   <= front_buf_o ^ w_swap;
            frame_start_o <= w_vs_rise;
            red_o         <= r_ve[L-2] ? w_gray : '0;
            green_o       <= r_ve[L-2] ? w_gray : '0;
            blue_o        <= r_ve[L-2] ? w_gray : '0;
        end
    end
endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// tb_vga_pixel_pipeline: randomized directed scenarios checked against a cycle-history reference model
module tb_vga_pixel_pipeline;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, hs, vs, ve, req;
    logic [16:0] pix;
    logic [7:0] rd_data, ram_q;
    logic [17:0] rd_addr;
    logic swap_ack, front_buf, frame_start, hs_o, vs_o;
    logic [3:0] red, green, blue;
    int checks = 0, errors = 0;
    logic hs_h[4], vs_h[4], ve_h[4];
    logic [17:0] a_h[4];
    logic fb_m, pend, done, ack_m, fs_m;

    vga_pixel_pipeline dut (
        .clk_i(clk), .reset_i(reset), .hsync_i(hs), .vsync_i(vs), .video_en_i(ve),
        .pixel_i(pix), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .swap_req_i(req),
        .swap_ack_o(swap_ack), .front_buf_o(front_buf), .frame_start_o(frame_start),
        .hsync_o(hs_o), .vsync_o(vs_o), .red_o(red), .green_o(green), .blue_o(blue)
    );

    function automatic logic [7:0] ram_f(logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {a[17], a[16], 6'h2B};
    endfunction

    always @(posedge clk) begin
        ram_q   <= ram_f(rd_addr);
        rd_data <= ram_q;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0] d;
        logic [3:0] col;
        @(posedge clk);
        #1;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hs_h[i] = 0; vs_h[i] = 0; ve_h[i] = 0; a_h[i] = '0;
            end
            fb_m = 0; pend = 0; done = 0; ack_m = 0; fs_m = 0;
        end else begin
            for (int i = 3; i > 0; i--) begin
                hs_h[i] = hs_h[i-1]; vs_h[i] = vs_h[i-1]; ve_h[i] = ve_h[i-1]; a_h[i] = a_h[i-1];
            end
            hs_h[0] = hs; vs_h[0] = vs; ve_h[0] = ve; a_h[0] = {fb_m, pix};
            fs_m  = vs_h[0] & ~vs_h[1];
            ack_m = 0;
            if (!req) begin
                pend = 0; done = 0;
            end else if (pend && fs_m) begin
                fb_m = ~fb_m; ack_m = 1; pend = 0; done = 1;
            end else if (!done) pend = 1;
        end
        d   = ram_f(a_h[3]);
        col = ve_h[3] ? d[7:4] : 4'h0;
        chk("rd_addr", rd_addr, a_h[0]);
        chk("hsync_o", hs_o, hs_h[3]);
        chk("vsync_o", vs_o, vs_h[3]);
        chk("red", red, col);
        chk("green", green, col);
        chk("blue", blue, col);
        chk("frame_start", frame_start, fs_m);
        chk("swap_ack", swap_ack, ack_m);
        chk("front_buf", front_buf, fb_m);
    endtask

    task automatic run(int n, bit rand_hs);
        repeat (n) begin
            if (rand_hs) hs = 1'($urandom);
            ve  = 1'($urandom);
            pix = 17'($urandom_range(0, 76799));
            step();
        end
    endtask

    initial begin
        reset = 1; hs = 0; vs = 0; ve = 0; req = 0; pix = '0;
        repeat (3) step();
        reset = 0;
        ve = 0;
        step();
        run(40, 1);
        hs = 1; run(96, 0); hs = 0; run(10, 0);
        req = 1; run(20, 1);
        vs = 1; run(6, 1); vs = 0; run(30, 1);
        vs = 1; run(6, 1); vs = 0; run(10, 1);
        req = 0; run(5, 1);
        req = 1; run(10, 1); req = 0; run(3, 1);
        vs = 1; run(5, 1); vs = 0; run(10, 1);
        vs = 1; req = 1; run(5, 1); vs = 0; run(20, 1);
        vs = 1; run(5, 1); vs = 0; run(10, 1);
        req = 0; run(5, 1);
        req = 1; run(10, 1);
        reset = 1; run(2, 1); reset = 0; req = 0; run(5, 1);
        vs = 1; run(5, 1); vs = 0; run(10, 1);
        repeat (2000) begin
            if ($urandom_range(0, 40) == 0) vs = ~vs;
            if ($urandom_range(0, 60) == 0) req = ~req;
            if ($urandom_range(0, 500) == 0) reset = 1;
            run(1, 1);
            reset = 0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_pipeline.md
Name: vga_pixel_pipeline

Overview:
Downstream consumer of the VGA sync pulse generator. It turns the generator's frame-buffer pixel index into a read address for the double-buffered frame RAM. It delay-matches hsync, vsync and video enable to the RAM read latency and drives registered 12-bit RGB (grayscale expansion) to the VGA DAC pins. It also owns front/back buffer selection and swaps buffers only during vertical sync, under a req/ack handshake with the camera capture writer.

Parameters:
PIXEL_ADDR_W, 17, width of pixel_i (76800-entry buffer at quarter resolution)
DATA_W, 8, grayscale sample width returned by frame RAM
COLOR_W, 4, bits per colour channel on output
RAM_LATENCY, 2, clocks from rd_addr_o registered to rd_data_i valid (legal range 1..4)

Ports:
clk_i  input  1  pixel clock (25 MHz domain)
reset_i  input  1  synchronous active-high reset
hsync_i  input  1  from sync generator, high during hsync pulse
vsync_i  input  1  from sync generator, high during vsync pulse
video_en_i  input  1  active-area flag from sync generator
pixel_i  input  PIXEL_ADDR_W  frame-buffer pixel index from sync generator
rd_addr_o  output  PIXEL_ADDR_W+1  RAM read address {front_buf_o, pixel index}
rd_data_i  input  DATA_W  RAM read data
swap_req_i  input  1  level request from writer: back buffer complete
swap_ack_o  output  1  one-cycle pulse: swap performed
front_buf_o  output  1  buffer currently displayed (0/1)
frame_start_o  output  1  one-cycle pulse on every vsync_i rising edge
hsync_o  output  1  delay-matched hsync
vsync_o  output  1  delay-matched vsync
red_o, green_o, blue_o  output  COLOR_W each  pixel colour

Behaviour:
- Reset: all outputs 0, front_buf_o=0, delay pipes cleared to 0, vsync edge register 0, FSM=IDLE. Reset mid-swap discards pending request; no ack issued.
- Address stage: rd_addr_o <= {front_buf_o, pixel_i} every cycle, unconditionally (1 clk).
- Delay match: hsync/vsync/video_en pass through a shift register of length L = 1 + RAM_LATENCY + 1 (addr reg + RAM + output reg). With defaults L=4: an input edge at cycle n appears on the output at n+4.
- Output stage (registered): if delayed video_en=1, red_o=green_o=blue_o=rd_data_i[DATA_W-1 -: COLOR_W]; else all 0. Colour is never nonzero while the delayed video_en is 0.
- Edge detect: vs_rise = vsync_i & ~vsync_q, where vsync_q is a 1-clk registered copy of vsync_i. frame_start_o <= vs_rise.
- Swap FSM:
  IDLE: swap_req_i=1 -> PENDING.
  PENDING: swap_req_i=0 -> IDLE, no swap (abort). Else on vs_rise: front_buf_o <= ~front_buf_o, swap_ack_o <= 1 for one clk -> WAIT_DROP.
  WAIT_DROP: hold until swap_req_i=0 -> IDLE. At most one swap per request.
- Simultaneity: swap_req_i rising in the same cycle as vs_rise while in IDLE goes only to PENDING; the swap occurs at the next frame's vs_rise.
- Toggle timing: front_buf_o toggles in the cycle after vs_rise. The first rd_addr_o using the new buffer is the following cycle. Vsync lies in vertical blanking, so the active area is never split across buffers.
- Widths: pixel_i is passed through unmodified, with no arithmetic and no wrap logic. The sync generator resets it per frame.

Test Plan:
- Reset for 3 clks, release with hsync_i=vsync_i=video_en_i=0 -> all outputs 0, rd_addr_o=0, front_buf_o=0.
- video_en_i pulse at cycle 10, pixel_i=0x00123, RAM model returning 0xA7 at latency 2 -> rd_addr_o=0x00123 at cycle 11; red/green/blue=0xA at cycle 14 only; 0 otherwise.
- hsync_i high cycles 20-115 -> hsync_o high cycles 24-119 exactly; vsync behaves identically.
- swap_req_i=1 mid-frame, then vsync_i rises -> frame_start_o and swap_ack_o each pulse 1 clk in the cycle after the edge; front_buf_o 0->1; rd_addr_o[17]=1 from the next cycle. Holding req high through a second vsync causes no second swap.
- swap_req_i=1 then dropped before vsync -> no ack, front_buf_o unchanged, frame_start_o still pulses.
- swap_req_i raised on the exact vs_rise cycle -> no swap that frame; swap and ack at the next vsync rise. Asserting reset_i while PENDING -> front_buf_o=0 and no ack after release.
